// File: rtl/text_editor_key_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : text_editor_key_ctrl_pkg                                       |
// | Purpose  : Scan-code constants, FSM state type and cursor move codes      |
// |            shared by the text editor key controller blocks.               |
// | Config   : CLEAR_SCREEN_EN adds the screen-clear state.                   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package text_editor_key_ctrl_pkg;

  // PS/2 Set-2 make codes and prefixes
  localparam logic [7:0] KEY_BKSP   = 8'h66;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_DEL    = 8'h71;

  // Blank cell content; the RAM reset fill uses the same value
  localparam logic [7:0] BLANK_CHAR = 8'h29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
`ifdef CLEAR_SCREEN_EN
    , ST_CLR
`endif
  } state_t;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_INC,
    MV_DEC,
    MV_UP,
    MV_DOWN,
    MV_ENTER
  } move_t;

  // Codes 01..7F are stored as characters when no special meaning applies
  function automatic logic is_printable(input logic [7:0] code);
    return (code != 8'h00) && !code[7];
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_editor_key_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : text_editor_key_ctrl_if                                        |
// | Purpose  : Scan-code input and RAM write-port bundle of the key          |
// |            controller. master = controller, slave = environment.         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface text_editor_key_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] scan_code;
  logic                  scan_valid;
  logic                  scan_ready;
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] cursor_addr;

  modport master (
    input  scan_code, scan_valid,
    output scan_ready, write, write_address, write_data, cursor_addr
  );

  modport slave (
    output scan_code, scan_valid,
    input  scan_ready, write, write_address, write_data, cursor_addr
  );
endinterface
`default_nettype wire

// File: rtl/text_editor_cursor_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : text_editor_cursor_step                                        |
// | Purpose  : Combinational cursor update; all arithmetic wraps modulo the  |
// |            buffer size, so row moves keep the column.                    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module text_editor_cursor_step
  import text_editor_key_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int COLS       = 32
) (
  input  logic [ADDR_WIDTH-1:0] cursor,
  input  move_t                 move,
  output logic [ADDR_WIDTH-1:0] next_cursor
);

  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] ROW_MASK = ~(COL_STEP - 1'b1);

  // Next cursor for the requested move; natural overflow gives the wrap
  always_comb begin
    next_cursor = cursor;
    case (move)
      MV_NONE:  next_cursor = cursor;
      MV_INC:   next_cursor = cursor + 1'b1;
      MV_DEC:   next_cursor = cursor - 1'b1;
      MV_UP:    next_cursor = cursor - COL_STEP;
      MV_DOWN:  next_cursor = cursor + COL_STEP;
      MV_ENTER: next_cursor = (cursor & ROW_MASK) + COL_STEP;
      default:  next_cursor = cursor;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/text_editor_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : text_editor_key_ctrl                                           |
// | Purpose  : Decodes PS/2 Set-2 scan codes into text buffer RAM writes     |
// |            and cursor moves. Outputs are registered; a code accepted in  |
// |            cycle N takes effect in cycle N+1.                            |
// | Config   : CLEAR_SCREEN_EN - Esc blanks the whole buffer, one cell per   |
// |            cycle, with scan_ready low for the duration.                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module text_editor_key_ctrl
  import text_editor_key_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int COLS       = 32
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  text_editor_key_ctrl_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] BLANK = DATA_WIDTH'(BLANK_CHAR);

  state_t                state;
  move_t                 move;
  logic                  accept;
  logic                  ready;
  logic [7:0]            code;
  logic [ADDR_WIDTH-1:0] cursor;
  logic [ADDR_WIDTH-1:0] step_cursor;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

`ifdef CLEAR_SCREEN_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  logic [ADDR_WIDTH-1:0] sweep;
  logic                  ready_q;
  assign ready = ready_q;
`else
  assign ready = 1'b1;
`endif

  assign code   = 8'(bus.scan_code);
  assign accept = bus.scan_valid && ready;

  assign bus.scan_ready    = ready;
  assign bus.write         = wr_en;
  assign bus.write_address = wr_addr;
  assign bus.write_data    = wr_data;
  assign bus.cursor_addr   = cursor;

  // Cursor move requested by the code accepted this cycle
  always_comb begin
    move = MV_NONE;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (code == KEY_BKSP)
            move = MV_DEC;
          else if (code == KEY_ENTER)
            move = MV_ENTER;
`ifdef CLEAR_SCREEN_EN
          else if (code == KEY_ESC)
            move = MV_NONE;
`endif
          else if (is_printable(code))
            move = MV_INC;
        end
        ST_EXT: begin
          case (code)
            KEY_LEFT:  move = MV_DEC;
            KEY_RIGHT: move = MV_INC;
            KEY_UP:    move = MV_UP;
            KEY_DOWN:  move = MV_DOWN;
            default:   move = MV_NONE;
          endcase
        end
        default: move = MV_NONE;
      endcase
    end
  end

  text_editor_cursor_step #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COLS       (COLS)
  ) u_cursor_step (
    .cursor      (cursor),
    .move        (move),
    .next_cursor (step_cursor)
  );

  // Prefix FSM with registered write port, cursor and ready outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      cursor  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= BLANK;
`ifdef CLEAR_SCREEN_EN
      ready_q <= 1'b1;
      sweep   <= '0;
`endif
    end else begin
      wr_en  <= 1'b0;
      cursor <= step_cursor;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (code == PFX_BRK) begin
              state <= ST_BRK;
            end else if (code == PFX_EXT) begin
              state <= ST_EXT;
`ifdef CLEAR_SCREEN_EN
            end else if (code == KEY_ESC) begin
              // First blank write goes out with the state change
              state   <= ST_CLR;
              ready_q <= 1'b0;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= BLANK;
              sweep   <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif
            end else if (code == KEY_BKSP) begin
              // Blank lands on the cell the cursor moves back onto
              wr_en   <= 1'b1;
              wr_addr <= step_cursor;
              wr_data <= BLANK;
            end else if (code == KEY_ENTER) begin
              wr_en <= 1'b0;
            end else if (is_printable(code)) begin
              wr_en   <= 1'b1;
              wr_addr <= cursor;
              wr_data <= DATA_WIDTH'(code);
            end
          end
        end
        ST_EXT: begin
          if (accept) begin
            state <= (code == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
            if (code == KEY_DEL) begin
              wr_en   <= 1'b1;
              wr_addr <= cursor;
              wr_data <= BLANK;
            end
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (accept)
            state <= ST_IDLE;
        end
`ifdef CLEAR_SCREEN_EN
        ST_CLR: begin
          if (wr_en && (wr_addr == LAST_ADDR)) begin
            // Last cell was written in the previous cycle
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            cursor  <= '0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= sweep;
            wr_data <= BLANK;
            sweep   <= sweep + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_editor_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_text_editor_key_ctrl                                        |
// | Purpose  : Directed and random scan-code stimulus against a behavioural  |
// |            editor model; outputs compared every cycle on falling edges.  |
// | Config   : CLEAR_SCREEN_EN enables the screen-clear scenarios.           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_text_editor_key_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int COLS  = 32;
  localparam int CELLS = 512;
  localparam int BLANK = 'h29;

  logic clk     = 1'b0;
  logic Reset_n = 1'b0;

  text_editor_key_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  text_editor_key_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COLS(COLS)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Editor model: what the outputs must show after each clock edge
  int m_cursor, m_waddr, m_wdata, m_sweep;
  bit m_write, m_ready, m_ext, m_skip;

  function automatic void model_reset();
    m_cursor = 0; m_write = 0; m_waddr = 0; m_wdata = BLANK;
    m_ready = 1; m_ext = 0; m_skip = 0; m_sweep = -1;
  endfunction

  function automatic void put(int addr, int data);
    m_write = 1; m_waddr = addr; m_wdata = data;
  endfunction

  function automatic void model_step(bit valid, int code);
    m_write = 0;
    if (m_sweep >= 0) begin
      if (m_sweep < CELLS) begin
        put(m_sweep, BLANK);
        m_sweep++;
      end else begin
        m_sweep = -1; m_ready = 1; m_cursor = 0;
      end
      return;
    end
    if (!(valid && m_ready)) return;
    if (m_skip) begin
      m_skip = 0;
      return;
    end
    if (m_ext) begin
      m_ext = 0;
      case (code)
        'hF0: m_skip = 1;
        'h6B: m_cursor = (m_cursor + CELLS - 1) % CELLS;
        'h74: m_cursor = (m_cursor + 1) % CELLS;
        'h75: m_cursor = (m_cursor + CELLS - COLS) % CELLS;
        'h72: m_cursor = (m_cursor + COLS) % CELLS;
        'h71: put(m_cursor, BLANK);
        default: ;
      endcase
      return;
    end
    case (code)
      'hF0: m_skip = 1;
      'hE0: m_ext = 1;
      'h66: begin
        m_cursor = (m_cursor + CELLS - 1) % CELLS;
        put(m_cursor, BLANK);
      end
      'h5A: m_cursor = ((m_cursor / COLS + 1) * COLS) % CELLS;
      default: begin
`ifdef CLEAR_SCREEN_EN
        if (code == 'h76) begin
          put(0, BLANK);
          m_ready = 0;
          m_sweep = 1;
        end else
`endif
        if (code >= 1 && code <= 'h7F) begin
          put(m_cursor, code);
          m_cursor = (m_cursor + 1) % CELLS;
        end
      end
    endcase
  endfunction

  initial model_reset();

  // Model advances on the same edges as the design
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) model_reset();
    else model_step(bus.scan_valid, int'(bus.scan_code));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("write", int'(bus.write), int'(m_write));
      chk("write_address", int'(bus.write_address), m_waddr);
      chk("write_data", int'(bus.write_data), m_wdata);
      chk("cursor_addr", int'(bus.cursor_addr), m_cursor);
      chk("scan_ready", int'(bus.scan_ready), int'(m_ready));
    end
  end

  task automatic send(input int code);
    @(negedge clk);
    bus.scan_valid = 1'b1;
    bus.scan_code  = 8'(code);
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 Reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic ext(input int code);
    send('hE0);
    send(code);
  endtask

  task automatic mid_reset_check();
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_write", int'(bus.write), 0);
    chk("async_rst_addr", int'(bus.write_address), 0);
    chk("async_rst_data", int'(bus.write_data), BLANK);
    chk("async_rst_cursor", int'(bus.cursor_addr), 0);
    chk("async_rst_ready", int'(bus.scan_ready), 1);
    @(negedge clk);
    Reset_n = 1'b1;
    send('h1C);
    chk("post_rst_write", int'(bus.write), 1);
    chk("post_rst_addr", int'(bus.write_address), 0);
    chk("post_rst_data", int'(bus.write_data), 'h1C);
  endtask

  initial begin
    bus.scan_valid = 1'b0;
    bus.scan_code  = '0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_cursor", int'(bus.cursor_addr), 0);
    chk("rst_ready", int'(bus.scan_ready), 1);
    chk("rst_data", int'(bus.write_data), BLANK);

    // Make then break of the same key
    send('h1C);
    chk("t1_write", int'(bus.write), 1);
    chk("t1_addr", int'(bus.write_address), 0);
    chk("t1_data", int'(bus.write_data), 'h1C);
    chk("t1_cursor", int'(bus.cursor_addr), 1);
    send('hF0);
    chk("t1_brk_nowrite", int'(bus.write), 0);
    send('h1C);
    chk("t1_brk_nowrite2", int'(bus.write), 0);
    chk("t1_cursor_hold", int'(bus.cursor_addr), 1);

    // Wrap at the end of the buffer
    do_reset();
    ext('h6B);
    chk("t2_left_wrap", int'(bus.cursor_addr), 511);
    send('h1C);
    chk("t2_write_addr", int'(bus.write_address), 511);
    chk("t2_cursor_wrap", int'(bus.cursor_addr), 0);
    send('h66);
    chk("t2_bksp_cursor", int'(bus.cursor_addr), 511);
    chk("t2_bksp_write", int'(bus.write), 1);
    chk("t2_bksp_addr", int'(bus.write_address), 511);
    chk("t2_bksp_data", int'(bus.write_data), BLANK);

    // Up / down with row wrap, extended break
    do_reset();
    repeat (5) send('h1C);
    chk("t3_cursor5", int'(bus.cursor_addr), 5);
    ext('h75);
    chk("t3_up_wrap", int'(bus.cursor_addr), 485);
    chk("t3_up_nowrite", int'(bus.write), 0);
    ext('h72);
    chk("t3_down", int'(bus.cursor_addr), 5);
    send('hE0); send('hF0); send('h72);
    chk("t3_extbrk_hold", int'(bus.cursor_addr), 5);
    chk("t3_extbrk_nowrite", int'(bus.write), 0);

    // Enter
    do_reset();
    send('h5A);
    chk("t4_enter0", int'(bus.cursor_addr), 32);
    repeat (8) send('h1C);
    send('h5A);
    chk("t4_enter40", int'(bus.cursor_addr), 64);
    do_reset();
    ext('h75);
    repeat (20) ext('h74);
    chk("t4_cursor500", int'(bus.cursor_addr), 500);
    send('h5A);
    chk("t4_enter_wrap", int'(bus.cursor_addr), 0);

`ifdef CLEAR_SCREEN_EN
    // Screen clear, with a code strobed mid-sweep
    begin
      int writes;
      do_reset();
      repeat (10) send('h1C);
      send('h76);
      writes = int'(bus.write);
      chk("t5_ready_low", int'(bus.scan_ready), 0);
      for (int i = 0; i < 600 && !bus.scan_ready; i++) begin
        bus.scan_valid = (i == 100);
        bus.scan_code  = 8'h1C;
        @(negedge clk);
        if (bus.write) writes++;
      end
      bus.scan_valid = 1'b0;
      chk("t5_write_count", writes, CELLS);
      chk("t5_ready_back", int'(bus.scan_ready), 1);
      chk("t5_cursor0", int'(bus.cursor_addr), 0);
    end
    // Asynchronous reset in the middle of a sweep
    send('h76);
    repeat (50) @(negedge clk);
    mid_reset_check();
`else
    // Esc is a plain character here
    do_reset();
    send('h76);
    chk("t5_esc_data", int'(bus.write_data), 'h76);
    chk("t5_esc_cursor", int'(bus.cursor_addr), 1);
    repeat (5) send('h2B);
    @(negedge clk);
    mid_reset_check();
`endif

    // Random traffic
    do_reset();
    repeat (3000) begin
      int sel;
      int code;
      @(negedge clk);
      sel = int'($urandom_range(0, 19));
      case (sel)
        0: code = 'hF0;
        1: code = 'hE0;
        2: code = 'h66;
        3: code = 'h5A;
        4: code = 'h6B;
        5: code = 'h74;
        6: code = 'h75;
        7: code = 'h72;
        8: code = 'h71;
        9: code = ($urandom_range(0, 29) == 0) ? 'h76 : 'h1C;
        default: code = int'($urandom_range(0, 255));
      endcase
      bus.scan_valid = ($urandom_range(0, 99) < 50);
      bus.scan_code  = 8'(code);
    end
    @(negedge clk);
    bus.scan_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
